// File: rtl/md_pkg.sv
// md_pkg: shared op/state encodings and constants for the multiply/divide unit
package md_pkg;
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} md_state_e;
  localparam logic [63:0] DIV_ZERO_Q = '1;
endpackage

// File: rtl/md_div_core.sv
// md_div_core: iterative radix-2 restoring unsigned divider, one quotient bit per clock
module md_div_core
  import md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             last
);
  logic [WIDTH-1:0] d;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   sh, diff;
  // partial remainder shifted left by one with the next dividend bit, and the trial subtraction
  always_comb begin
    sh   = {rem, quo[WIDTH-1]};
    diff = sh - {1'b0, d};
  end
  assign last = cnt == CNT_W'(1);
  // quotient bits shift in at the bottom of quo as dividend bits shift out of the top
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      d   <= '0;
    end else if (start) begin
      quo <= dividend;
      rem <= '0;
      d   <= divisor;
      cnt <= CNT_W'(WIDTH);
    end else if (cnt != '0) begin
      quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
      rem <= diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit producing a single registered HI/LO write per accepted op
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [WIDTH-1:0] hi_cur,
  input  logic [WIDTH-1:0] lo_cur,
  input  logic             flush,
  output logic             busy,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_wr,
  output logic [WIDTH-1:0] lo_wr
);
  md_state_e          state, state_n;
  logic               busy_n, we_n, div_go, sdiv, mul_s, dz, neg_q, neg_r, last;
  logic [WIDTH-1:0]   hi_n, lo_n, a_r, b_r, quo, rem, rs_abs, rt_abs;
  logic [2*WIDTH-1:0] ea, eb, prod;
  assign sdiv   = op == MD_DIV;
  assign rs_abs = (sdiv && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_abs = (sdiv && rt_val[WIDTH-1]) ? -rt_val : rt_val;
  // sign- or zero-extend to full product width so a single truncated multiply serves both
  always_comb begin
    ea   = mul_s ? {{WIDTH{a_r[WIDTH-1]}}, a_r} : {{WIDTH{1'b0}}, a_r};
    eb   = mul_s ? {{WIDTH{b_r[WIDTH-1]}}, b_r} : {{WIDTH{1'b0}}, b_r};
    prod = ea * eb;
  end
  md_div_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_go),
    .abort   (flush),
    .dividend(rs_abs),
    .divisor (rt_abs),
    .quo     (quo),
    .rem     (rem),
    .last    (last)
  );
  // next state and next registered outputs; flush cancels everything, including a completing write
  always_comb begin
    state_n = state;
    busy_n  = 1'b0;
    we_n    = 1'b0;
    hi_n    = hi_wr;
    lo_n    = lo_wr;
    div_go  = 1'b0;
    case (state)
      ST_IDLE:
        if (start)
          case (op)
            MD_MULT, MD_MULTU: begin
              state_n = ST_MUL;
              busy_n  = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              state_n = rt_val == '0 ? ST_FIX : ST_DIV;
              busy_n  = 1'b1;
              div_go  = rt_val != '0;
            end
            MD_MTHI: begin
              we_n = 1'b1;
              hi_n = rs_val;
              lo_n = lo_cur;
            end
            MD_MTLO: begin
              we_n = 1'b1;
              hi_n = hi_cur;
              lo_n = rs_val;
            end
            default: ;
          endcase
      ST_MUL: begin
        state_n = ST_IDLE;
        we_n    = 1'b1;
        hi_n    = prod[2*WIDTH-1:WIDTH];
        lo_n    = prod[WIDTH-1:0];
      end
      ST_DIV: begin
        busy_n  = 1'b1;
        state_n = last ? ST_FIX : ST_DIV;
      end
      ST_FIX: begin
        state_n = ST_IDLE;
        we_n    = 1'b1;
        hi_n    = dz ? a_r : (neg_r ? -rem : rem);
        lo_n    = dz ? DIV_ZERO_Q[WIDTH-1:0] : (neg_q ? -quo : quo);
      end
    endcase
    if (flush) begin
      state_n = ST_IDLE;
      busy_n  = 1'b0;
      we_n    = 1'b0;
      hi_n    = hi_wr;
      lo_n    = lo_wr;
      div_go  = 1'b0;
    end
  end
  // state register
  always_ff @(posedge clk) state <= rst ? ST_IDLE : state_n;
  // registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      hilo_we <= 1'b0;
      hi_wr   <= '0;
      lo_wr   <= '0;
    end else begin
      busy    <= busy_n;
      hilo_we <= we_n;
      hi_wr   <= hi_n;
      lo_wr   <= lo_n;
    end
  end
  // operand and sign capture at acceptance; a_r doubles as the divide-by-zero remainder
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      mul_s <= 1'b0;
      dz    <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      a_r   <= rs_val;
      b_r   <= rt_val;
      mul_s <= op == MD_MULT;
      dz    <= rt_val == '0;
      neg_q <= sdiv && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
      neg_r <= sdiv && rs_val[WIDTH-1];
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: table-driven and sequence checks for the multiply/divide unit
module tb_md_unit;
  logic        clk, rst, start, flush, busy, hilo_we;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val, hi_cur, lo_cur, hi_wr, lo_wr;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs, rt, hc, lc, hi, lo;
    int          nb;
  } vec_t;
  vec_t v[16];
  md_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .hi_cur(hi_cur), .lo_cur(lo_cur), .flush(flush), .busy(busy), .hilo_we(hilo_we),
    .hi_wr(hi_wr), .lo_wr(lo_wr)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic go(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] hc, input logic [31:0] lc);
    op = o; rs_val = a; rt_val = b; hi_cur = hc; lo_cur = lc; start = 1;
    step();
    start = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    logic seen;
    rst = 1; start = 0; flush = 0; op = 0; rs_val = 0; rt_val = 0; hi_cur = 0; lo_cur = 0;
    step();
    step();
    rst = 0;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_we", {31'd0, hilo_we}, 0);
    chk("rst_hi", hi_wr, 0);
    chk("rst_lo", lo_wr, 0);
    v[0]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA, 1};
    v[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h00000001, 1};
    v[2]  = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 32'h3FFFFFFF, 32'h00000001, 1};
    v[3]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'h00000000, 32'h00000001, 1};
    v[4]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 0, 0, 32'h00000002, 32'hFFFFFFFA, 1};
    v[5]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    v[6]  = '{3'd3, 32'd100,      32'd0,        0, 0, 32'd100,      32'hFFFFFFFF, 1};
    v[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h00000000, 32'h80000000, 33};
    v[8]  = '{3'd3, 32'd100,      32'd7,        0, 0, 32'd2,        32'd14,       33};
    v[9]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        0, 0, 32'd1,        32'h7FFFFFFC, 33};
    v[10] = '{3'd2, 32'd7,        32'hFFFFFFFE, 0, 0, 32'd1,        32'hFFFFFFFD, 33};
    v[11] = '{3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 0, 0, 32'hFFFFFFFF, 32'd3,        33};
    v[12] = '{3'd5, 32'h1234,     32'd9, 32'hAA, 32'h55, 32'hAA,    32'h1234,     0};
    v[13] = '{3'd4, 32'h5678,     32'd9, 32'hCC, 32'hBB, 32'h5678,  32'hBB,       0};
    v[14] = '{3'd2, 32'd0,        32'd5,        0, 0, 32'd0,        32'd0,        33};
    v[15] = '{3'd2, 32'hFFFFFFFB, 32'd0,        0, 0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1};
    for (int i = 0; i < 16; i++) begin
      go(v[i].op, v[i].rs, v[i].rt, v[i].hc, v[i].lc);
      n = 0;
      while (busy && n < 100) begin
        n++;
        step();
      end
      chk($sformatf("v%0d_busy_cycles", i), 32'(n), 32'(v[i].nb));
      chk($sformatf("v%0d_we", i), {31'd0, hilo_we}, 1);
      chk($sformatf("v%0d_hi", i), hi_wr, v[i].hi);
      chk($sformatf("v%0d_lo", i), lo_wr, v[i].lo);
      step();
      chk($sformatf("v%0d_we_drop", i), {31'd0, hilo_we}, 0);
    end
    go(3'd0, 32'd2, 32'd3, 0, 0);
    flush = 1;
    step();
    flush = 0;
    chk("flush_done_busy", {31'd0, busy}, 0);
    chk("flush_done_we", {31'd0, hilo_we}, 0);
    chk("flush_done_hi", hi_wr, v[15].hi);
    chk("flush_done_lo", lo_wr, v[15].lo);
    flush = 1;
    go(3'd4, 32'hDEAD, 0, 0, 32'hBEEF);
    flush = 0;
    chk("flush_idle_we", {31'd0, hilo_we}, 0);
    chk("flush_idle_hi", hi_wr, v[15].hi);
    go(3'd6, 32'd1, 32'd1, 0, 0);
    chk("op6_busy", {31'd0, busy}, 0);
    chk("op6_we", {31'd0, hilo_we}, 0);
    step();
    chk("op6_we_late", {31'd0, hilo_we}, 0);
    go(3'd3, 32'd100, 32'd7, 0, 0);
    for (int i = 0; i < 9; i++) step();
    flush = 1;
    step();
    flush = 0;
    chk("flush_busy", {31'd0, busy}, 0);
    seen = hilo_we;
    for (int i = 0; i < 40; i++) begin
      step();
      seen = seen | hilo_we | busy;
    end
    chk("flush_no_we", {31'd0, seen}, 0);
    go(3'd3, 32'd100, 32'd7, 0, 0);
    n = 0;
    seen = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 5) begin
        start = 1; op = 3'd4; rs_val = 32'hDEAD;
      end else start = 0;
      seen = seen | hilo_we;
      step();
    end
    start = 0;
    chk("restart_busy_cycles", 32'(n), 33);
    chk("restart_early_we", {31'd0, seen}, 0);
    chk("restart_hi", hi_wr, 32'd2);
    chk("restart_lo", lo_wr, 32'd14);
    step();
    chk("restart_not_queued", {30'd0, busy, hilo_we}, 0);
    go(3'd3, 32'd100, 32'd7, 0, 0);
    for (int i = 0; i < 19; i++) step();
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_we", {31'd0, hilo_we}, 0);
    chk("mid_rst_hi", hi_wr, 0);
    chk("mid_rst_lo", lo_wr, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      seen = seen | hilo_we | busy;
    end
    chk("mid_rst_quiet", {31'd0, seen}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
